rr_sel_arbiter: RTL
===================

Name: rr_sel_arbiter

Overview:
Round-robin arbiter for the 4-source shared bus built from a 2-to-4 decoder and tristate buffers.
- Takes 4 request lines and produces the registered 2-bit encoded select (sel_a = MSB, sel_b = LSB) that drives the decoder's a/b inputs.
- Produces sel_valid, which gates the tristate enables.
- Limits how long one source may hold the bus.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one owner keeps the grant while holding; legal range 1..7.
- CW, 3, width of the internal hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per source; req[i] asks for source i
- hold  input  1  current owner asks to keep the bus next cycle
- sel_a  output  1  select MSB to decoder input a
- sel_b  output  1  select LSB to decoder input b
- sel_valid  output  1  a grant is active; the tristate enable gate
- owner_cnt  output  CW  cycles the current owner has held the grant, 1..HOLD_MAX; 0 when idle

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values:
  - sel_a=0, sel_b=0, sel_valid=0, owner_cnt=0.
  - State IDLE, last-winner pointer ptr=3, so the first search starts at source 0.
- All outputs are registered. A request sampled at edge n is reflected on the outputs after edge n; no combinational path from req to the outputs.
- Round-robin search: first index with req set, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). The previous owner is always checked last.
- State IDLE:
  - Any req set: load sel with the search winner, set ptr to the winner, sel_valid=1, owner_cnt=1, go to GRANT.
  - No req: stay IDLE; sel keeps its last value and sel_valid=0.
- State GRANT (owner = ptr):
  - Keep condition: req[owner] && hold && owner_cnt < HOLD_MAX. When true, sel is unchanged and owner_cnt increments.
  - Release condition: anything else.
- On release:
  - Run the search. A winner found: switch in the same edge with no idle bubble; sel=winner, ptr=winner, owner_cnt=1, sel_valid stays 1.
  - The owner is the only requester (including at HOLD_MAX): it is re-granted. sel is unchanged and owner_cnt restarts at 1.
  - No requests: go to IDLE with sel_valid=0 and owner_cnt=0; sel holds.
- hold is ignored in IDLE and for non-owners.
- Simultaneous requests: the fixed priority order is the rotation from ptr+1. No source waits more than 3 grants.
- Reset mid-grant wins over everything. On the next edge the outputs and ptr return to their reset values.
- owner_cnt never exceeds HOLD_MAX and never wraps.
- With HOLD_MAX=1 every grant lasts exactly one cycle.
- sel_valid=0 guarantees no tristate driver is enabled, whatever the sel value.

Test Plan:
1. Reset, then req=0001, hold=0 → after 1 edge: sel_a/sel_b=00, sel_valid=1, owner_cnt=1. Next edge with req=0000 → sel_valid=0, sel stays 00, owner_cnt=0.
2. req=1111, hold=0 held for 5 edges from reset → sel sequence 00, 01, 10, 11, 00; sel_valid stays 1 throughout; owner_cnt=1 every cycle.
3. HOLD_MAX=4, req=0110, hold=1 → sel=01 for 4 cycles (owner_cnt 1, 2, 3, 4), then sel=10 with owner_cnt=1. It then holds 4 cycles before returning to 01.
4. HOLD_MAX=4, req=1000, hold=1 for 10 cycles → sel=11 throughout, sel_valid never drops. owner_cnt runs 1, 2, 3, 4, 1, 2, 3, 4, 1, 2.
5. Grant active on source 2 with owner_cnt=3; rst=1 for one edge → sel=00, sel_valid=0, owner_cnt=0. With req=0100 still set, the next edge grants sel=10, owner_cnt=1.
6. Owner 1 drops req while req[0] and req[3] are set → the next edge grants source 3 (ptr+2 comes before ptr+3), sel=11, owner_cnt=1, with no sel_valid gap.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter for a 4-source shared bus.
// It produces the registered 2-bit select (sel_a = MSB, sel_b = LSB) that drives the bus decoder.
// sel_valid gates the tristate enables.
// A grant lasts while the owner keeps req and hold high, up to HOLD_MAX cycles.
// After that, the bus rotates to the next requester.
module rr_sel_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic          hold,
  output logic          sel_a,
  output logic          sel_b,
  output logic          sel_valid,
  output logic [CW-1:0] owner_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [1:0]    ptr, ptr_next;
  logic [1:0]    sel, sel_next;
  logic          valid_next;
  logic [CW-1:0] cnt_next;

  logic          found;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          keep;

  // Rotating search from ptr+1; the previous owner (offset 4 == ptr) is checked last
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && !found) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and next-output decision for the IDLE/GRANT controller
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    valid_next = sel_valid;
    cnt_next   = owner_cnt;
    keep       = req[ptr] && hold && (owner_cnt < CW'(HOLD_MAX));
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          ptr_next   = winner;
          sel_next   = winner;
          valid_next = 1'b1;
          cnt_next   = CW'(1);
        end else begin
          valid_next = 1'b0;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (keep) begin
          cnt_next = owner_cnt + CW'(1);
        end else if (found) begin
          ptr_next   = winner;
          sel_next   = winner;
          valid_next = 1'b1;
          cnt_next   = CW'(1);
        end else begin
          state_next = IDLE;
          valid_next = 1'b0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // State and output registers; synchronous reset restarts the search at source 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      sel       <= 2'd0;
      sel_valid <= 1'b0;
      owner_cnt <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      sel       <= sel_next;
      sel_valid <= valid_next;
      owner_cnt <= cnt_next;
    end
  end

  assign sel_a = sel[1];
  assign sel_b = sel[0];

endmodule
